// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 scan controller.
package hc595_pkg;
    localparam int WORD_W = 16;
    localparam int SEG_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH_LO,
        LATCH_HI,
        HOLD
    } scan_state_e;

    // Segment byte goes out first, so it lands in the second HC595 of the chain.
    typedef struct packed {
        logic [SEG_W-1:0] seg;
        logic [SEG_W-1:0] sel;
    } hc595_word_t;

    function automatic logic [SEG_W-1:0] blank_byte(input bit active_low);
        return active_low ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    endfunction
endpackage

// File: rtl/hc595_refresh_timer.sv
// Free-running digit-slot timer with a single-entry pending flag for ticks
// that arrive while a word is still being shifted out.
module hc595_refresh_timer #(
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic take,
    output logic tick,
    output logic pending
);
    localparam int CW = $clog2(REFRESH_CYCLES);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            // Entering LOAD consumes the request; a tick in that same cycle is dropped.
            if (take)
                pending <= 1'b0;
            else if (tick)
                pending <= 1'b1;
        end
    end
endmodule

// File: rtl/hc595_scan_ctrl.sv
// Multiplexed 7-segment scan controller driving two chained 74HC595s:
// one 16-bit word per refresh slot, then a latch pulse, digits round-robin.
module hc595_scan_ctrl
    import hc595_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 50,
    parameter int REFRESH_CYCLES = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*NUM_DIGITS-1:0] seg_data,
    input  logic                    blank,
    output logic                    ds,
    output logic                    shcp,
    output logic                    stcp,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SUB_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    scan_state_e       state, state_n;
    logic [WORD_W-1:0] shreg, shreg_n;
    logic [3:0]        bit_cnt, bit_n;
    logic [SUB_W-1:0]  sub_cnt, sub_n;
    logic [DW-1:0]     digit_idx, idx_n;
    logic              sub_done;
    logic              tick, pending;
    logic [SEG_W-1:0]  seg_cur;
    hc595_word_t       load_word;

    hc595_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .take    (state_n == LOAD),
        .tick    (tick),
        .pending (pending)
    );

    always_comb begin
        seg_cur = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (digit_idx == DW'(i)) seg_cur = seg_data[8*i +: 8];
        load_word.seg = blank ? blank_byte(SEG_ACTIVE_LOW) : seg_cur;
        load_word.sel = DIG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++)
            if (digit_idx == DW'(i)) load_word.sel[i] = !DIG_ACTIVE_LOW;
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bit_n    = bit_cnt;
        sub_n    = sub_cnt;
        idx_n    = digit_idx;
        sub_done = (sub_cnt == SUB_W'(CLK_DIV - 1));
        case (state)
            IDLE, HOLD: if (tick || pending) state_n = LOAD;
            LOAD: begin
                shreg_n = load_word;
                bit_n   = '0;
                sub_n   = '0;
                state_n = SHIFT_LO;
            end
            SHIFT_LO: begin
                sub_n = sub_done ? '0 : sub_cnt + 1'b1;
                if (sub_done) state_n = SHIFT_HI;
            end
            SHIFT_HI: begin
                sub_n = sub_done ? '0 : sub_cnt + 1'b1;
                if (sub_done) begin
                    shreg_n = shreg << 1;
                    if (bit_cnt == 4'd15) begin
                        state_n = LATCH_LO;
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        state_n = SHIFT_LO;
                    end
                end
            end
            LATCH_LO: begin
                sub_n = sub_done ? '0 : sub_cnt + 1'b1;
                if (sub_done) state_n = LATCH_HI;
            end
            LATCH_HI: begin
                sub_n = sub_done ? '0 : sub_cnt + 1'b1;
                if (sub_done) begin
                    state_n = HOLD;
                    idx_n   = (digit_idx == DW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pins are registered from the next-state view so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            sub_cnt    <= '0;
            digit_idx  <= '0;
            ds         <= 1'b0;
            shcp       <= 1'b0;
            stcp       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_n;
            sub_cnt    <= sub_n;
            digit_idx  <= idx_n;
            ds         <= (state_n == SHIFT_LO || state_n == SHIFT_HI) ? shreg_n[WORD_W-1] : 1'b0;
            shcp       <= (state_n == SHIFT_HI);
            stcp       <= (state_n == LATCH_HI);
            busy       <= (state_n != IDLE) && (state_n != HOLD);
            frame_done <= (state == LATCH_HI) && sub_done && (digit_idx == DW'(NUM_DIGITS - 1));
        end
    end
endmodule
